// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: pixel tick, raster counters, sync/blank/de generation
// and a request/ack pixel fetch from VRAM with one pixel period of video latency.
module vga_timing_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_en,
    output logic              hblank,
    output logic              vblank,
    output logic              frame_irq,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [7:0]        rd_data,
    output logic              underrun,
    input  logic              underrun_clr,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              de,
    output logic [7:0]        rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_ON    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_OFF   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_ON    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_OFF   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0]     div;
    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic              run;
    logic [ADDR_W-1:0] fetch_ptr;
    logic [7:0]        data_q;
    logic              valid;

    logic              pix_ce;
    logic [HW-1:0]     h_nxt;
    logic [VW-1:0]     v_nxt;
    logic              cur_active;
    logic              nxt_active;
    logic              hs_cur;
    logic              vs_cur;
    logic              ack_now;

    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    always_comb begin
        pix_ce     = (div == DIV_LAST);
        h_nxt      = (hcnt == H_LAST) ? '0 : hcnt + HW'(1);
        v_nxt      = vcnt;
        if (hcnt == H_LAST) begin
            v_nxt = (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        end
        cur_active = (hcnt < H_ACT) && (vcnt < V_ACT);
        nxt_active = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_cur     = (hcnt >= HS_ON) && (hcnt < HS_OFF);
        vs_cur     = (vcnt >= VS_ON) && (vcnt < VS_OFF);
        ack_now    = rd_req && rd_ack;
    end

    // NOTE: all state updates use non-blocking assignments so later statements
    // in this block override earlier ones without read-after-write ordering issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            hcnt      <= '0;
            vcnt      <= '0;
            run       <= 1'b0;
            fetch_ptr <= '0;
            data_q    <= '0;
            valid     <= 1'b0;
            hblank    <= 1'b1;
            vblank    <= 1'b1;
            frame_irq <= 1'b0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            underrun  <= 1'b0;
            hsync_n   <= 1'b1;
            vsync_n   <= 1'b1;
            de        <= 1'b0;
            rgb       <= '0;
        end else begin
            frame_irq <= 1'b0;
            // A coincident underrun further down overrides this clear.
            if (underrun_clr) begin
                underrun <= 1'b0;
            end

            if (!vga_en) begin
                div       <= '0;
                hcnt      <= '0;
                vcnt      <= '0;
                run       <= 1'b0;
                fetch_ptr <= '0;
                valid     <= 1'b0;
                hblank    <= 1'b1;
                vblank    <= 1'b1;
                rd_req    <= 1'b0;
                rd_addr   <= '0;
                hsync_n   <= 1'b1;
                vsync_n   <= 1'b1;
                de        <= 1'b0;
                rgb       <= '0;
            end else begin
                run <= 1'b1;
                div <= pix_ce ? '0 : div + DW'(1);

                if (!run) begin
                    // Enable enters position (0,0): fetch its pixel straight away.
                    rd_req    <= 1'b1;
                    rd_addr   <= '0;
                    fetch_ptr <= ADDR_W'(1);
                    hblank    <= 1'b0;
                    vblank    <= 1'b0;
                end else begin
                    if (ack_now) begin
                        rd_req <= 1'b0;
                        data_q <= rd_data;
                        valid  <= 1'b1;
                    end

                    if (pix_ce) begin
                        hcnt      <= h_nxt;
                        vcnt      <= v_nxt;
                        hblank    <= (h_nxt >= H_ACT);
                        vblank    <= (v_nxt >= V_ACT);
                        frame_irq <= (h_nxt == '0) && (v_nxt == V_ACT);

                        // Video side registers the pixel period that is ending now.
                        hsync_n <= !hs_cur;
                        vsync_n <= !vs_cur;
                        de      <= cur_active;
                        if (!cur_active) begin
                            rgb <= '0;
                        end else if (ack_now) begin
                            rgb <= rd_data;
                        end else if (valid) begin
                            rgb <= data_q;
                        end else begin
                            rgb <= '0;
                        end
                        valid <= 1'b0;

                        if (cur_active && rd_req && !rd_ack) begin
                            underrun <= 1'b1;
                        end

                        if (nxt_active) begin
                            rd_req <= 1'b1;
                            if ((h_nxt == '0) && (v_nxt == '0)) begin
                                rd_addr   <= '0;
                                fetch_ptr <= ADDR_W'(1);
                            end else begin
                                rd_addr   <= fetch_ptr;
                                fetch_ptr <= fetch_ptr + ADDR_W'(1);
                            end
                        end else begin
                            rd_req <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule
